// File: rtl/vga_signal_generator.sv
// Video timing and test-pattern back end for electron_beam_positioner.
// Turns the per-clock beam position and wrap pulses into registered syncs,
// display enable and 12-bit RGB. It also checks the position stream for
// sequence faults and counts frames.
//
// Ports:
//   clock, reset                  pixel clock, async active-low reset
//   instantaneous_beam_position   [0] = column x, [1] = row y
//   beam2left_signal              pulse at x == 0
//   beam2top_signal               pulse at (0,0); latches mode and solid colour
//   pattern_select, solid_color   test-pattern mode and mode-3 colour
//   error_clear                   synchronous clear of sequence_error
//   hsync, vsync, display_enable  timing outputs, 2 cycles after the input
//   red, green, blue              pixel colour, aligned with display_enable
//   frame_count                   frames started since reset
//   sequence_error                sticky position-stream fault flag
module vga_signal_generator #(
   parameter int unsigned H_VISIBLE       = 640,
   parameter int unsigned H_FRONT         = 16,
   parameter int unsigned H_SYNC          = 96,
   parameter int unsigned H_BACK          = 48,
   parameter int unsigned V_VISIBLE       = 480,
   parameter int unsigned V_FRONT         = 10,
   parameter int unsigned V_SYNC          = 2,
   parameter int unsigned V_BACK          = 33,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0][10:0] instantaneous_beam_position,
   input  logic             beam2left_signal,
   input  logic             beam2top_signal,
   input  logic [1:0]       pattern_select,
   input  logic [11:0]      solid_color,
   input  logic             error_clear,
   output logic             hsync,
   output logic             vsync,
   output logic             display_enable,
   output logic [3:0]       red,
   output logic [3:0]       green,
   output logic [3:0]       blue,
   output logic [15:0]      frame_count,
   output logic             sequence_error
);

   localparam int unsigned POS_W    = 11;
   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned BAR_W    = H_VISIBLE / 8;
   localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;

   logic [POS_W-1:0] x_in, y_in;
   logic             in_range_c, hs_act_c, vs_act_c, de_c;
   logic             x_wrap_c, seq_fault_c;
   logic [POS_W-1:0] exp_x_c, exp_y_c;

   // Stage-1 state
   logic [POS_W-1:0] x_s1, y_s1;
   logic             hs_s1, vs_s1, de_s1, primed;
   logic [1:0]       mode_q;
   logic [11:0]      solid_q;

   // Stage-2 colour
   logic [2:0]       bar_c;
   logic [11:0]      pix_c;

   assign x_in = instantaneous_beam_position[0];
   assign y_in = instantaneous_beam_position[1];

   // Region decode of the incoming sample; syncs are suppressed off-raster
   always_comb begin
      in_range_c = (x_in < POS_W'(H_TOTAL)) && (y_in < POS_W'(V_TOTAL));
      hs_act_c   = in_range_c && (x_in >= POS_W'(HS_START)) && (x_in < POS_W'(HS_END));
      vs_act_c   = in_range_c && (y_in >= POS_W'(VS_START)) && (y_in < POS_W'(VS_END));
      de_c       = (x_in < POS_W'(H_VISIBLE)) && (y_in < POS_W'(V_VISIBLE));
   end

   // Next position predicted from the previous sample held in stage 1
   always_comb begin
      x_wrap_c = (x_s1 == POS_W'(H_TOTAL - 1));
      exp_x_c  = x_wrap_c ? '0 : x_s1 + POS_W'(1);
      exp_y_c  = y_s1;
      if (x_wrap_c)
         exp_y_c = (y_s1 == POS_W'(V_TOTAL - 1)) ? '0 : y_s1 + POS_W'(1);
      seq_fault_c = !in_range_c ||
                    (primed && ((x_in != exp_x_c) || (y_in != exp_y_c) ||
                                (beam2left_signal != (x_in == '0)) ||
                                (beam2top_signal  != ((x_in == '0) && (y_in == '0)))));
   end

   // Stage 1: position, decoded regions, frame state and fault flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_s1           <= '0;
         y_s1           <= '0;
         hs_s1          <= 1'b0;
         vs_s1          <= 1'b0;
         de_s1          <= 1'b0;
         primed         <= 1'b0;
         mode_q         <= '0;
         solid_q        <= '0;
         frame_count    <= '0;
         sequence_error <= 1'b0;
      end else begin
         x_s1   <= x_in;
         y_s1   <= y_in;
         hs_s1  <= hs_act_c;
         vs_s1  <= vs_act_c;
         de_s1  <= de_c;
         primed <= 1'b1;
         if (beam2top_signal) begin
            mode_q      <= pattern_select;
            solid_q     <= solid_color;
            frame_count <= frame_count + 16'd1;
         end
         // A new fault outranks a simultaneous clear
         if (seq_fault_c)
            sequence_error <= 1'b1;
         else if (error_clear)
            sequence_error <= 1'b0;
      end
   end

   // Colour-bar index: x / BAR_W without a divider
   always_comb begin
      bar_c = '0;
      for (int unsigned i = 1; i < 8; i++)
         if (x_s1 >= POS_W'(i * BAR_W))
            bar_c = 3'(i);
   end

   // Pattern engine; black outside the visible area.
   // Bar order white..black is the bitwise complement of the index on {g,r,b}.
   always_comb begin
      pix_c = '0;
      if (de_s1) begin
         case (mode_q)
            2'd0: pix_c = {{4{~bar_c[1]}}, {4{~bar_c[2]}}, {4{~bar_c[0]}}};
            2'd1: pix_c = (x_s1[5] ^ y_s1[5]) ? 12'hFFF : 12'h000;
            2'd2: pix_c = {x_s1[9:6], y_s1[8:5], frame_count[3:0]};
            2'd3: pix_c = solid_q;
         endcase
      end
   end

   // Stage 2: aligned registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hsync          <= SYNC_IDLE;
         vsync          <= SYNC_IDLE;
         display_enable <= 1'b0;
         red            <= '0;
         green          <= '0;
         blue           <= '0;
      end else begin
         hsync          <= SYNC_IDLE ^ hs_s1;
         vsync          <= SYNC_IDLE ^ vs_s1;
         display_enable <= de_s1;
         red            <= pix_c[11:8];
         green          <= pix_c[7:4];
         blue           <= pix_c[3:0];
      end
   end

endmodule

// File: tb/tb_vga_signal_generator.sv
// Self-checking bench for vga_signal_generator using a reduced raster
// (160 x 48 total) so several whole frames fit in a short run.
module tb_vga_signal_generator;

   localparam int HV = 128, HF = 8, HS = 16, HB = 8;
   localparam int VV = 40,  VF = 2, VS = 2,  VB = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;

   logic             clock = 1'b0;
   logic             reset;
   logic [1:0][10:0] beam;
   logic             b2l, b2t, error_clear;
   logic [1:0]       pattern_select;
   logic [11:0]      solid_color;
   logic             hsync, vsync, display_enable, sequence_error;
   logic [3:0]       red, green, blue;
   logic [15:0]      frame_count;

   vga_signal_generator #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .clock                       (clock),
      .reset                       (reset),
      .instantaneous_beam_position (beam),
      .beam2left_signal            (b2l),
      .beam2top_signal             (b2t),
      .pattern_select              (pattern_select),
      .solid_color                 (solid_color),
      .error_clear                 (error_clear),
      .hsync                       (hsync),
      .vsync                       (vsync),
      .display_enable              (display_enable),
      .red                         (red),
      .green                       (green),
      .blue                        (blue),
      .frame_count                 (frame_count),
      .sequence_error              (sequence_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic hs, vs, de;
      logic [11:0] rgb;
      logic [15:0] fc;
      logic err;
   } exp_t;

   typedef struct {
      int x; int y; logic top; logic [1:0] psel; logic [11:0] scol;
      logic hs, vs, de; logic [11:0] rgb;
   } vec_t;

   int n_checks = 0, n_fail = 0;
   exp_t p0, p1;
   logic [15:0] m_fc;
   logic [1:0]  m_mode;
   logic [11:0] m_solid;
   logic        m_err, m_primed;
   int          m_prev;
   logic [1:0]  want_psel = '0;
   logic [11:0] want_scol = '0;
   logic        want_clr = 1'b0;
   logic        rel_pending = 1'b0;
   logic        rnd = 1'b0;
   int          cx = 0, cy = 0;
   logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};
   vec_t tbl [28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t reset_rec();
      exp_t e;
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.rgb = '0; e.fc = '0; e.err = 1'b0;
      return e;
   endfunction

   // Reference colour straight from the pattern definitions
   function automatic logic [11:0] colour(input int x, input int y);
      case (m_mode)
         2'd0:    return bar_tab[x / (HV / 8)];
         2'd1:    return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
         2'd2:    return {4'((x / 64) % 16), 4'((y / 32) % 16), m_fc[3:0]};
         default: return m_solid;
      endcase
   endfunction

   // Drive one sample, checking outputs against the model two samples back
   task automatic step(input int x, input int y, input logic l, input logic t);
      exp_t e;
      int   idx, exp_idx;
      logic inr, detect;
      @(negedge clock);
      if (rel_pending) begin
         reset = 1'b1;
         rel_pending = 1'b0;
      end
      chk("video", 32'({hsync, vsync, display_enable, red, green, blue}),
          32'({p1.hs, p1.vs, p1.de, p1.rgb}));
      chk("state", 32'({frame_count, sequence_error}), 32'({p0.fc, p0.err}));
      beam = {11'(y), 11'(x)};
      b2l = l; b2t = t;
      pattern_select = want_psel; solid_color = want_scol; error_clear = want_clr;
      inr     = (x < HT) && (y < VT);
      idx     = y * HT + x;
      exp_idx = (m_prev + 1) % (HT * VT);
      if (t) begin
         m_fc = m_fc + 16'd1; m_mode = want_psel; m_solid = want_scol;
      end
      detect = !inr || (m_primed && ((idx != exp_idx) || (l != (x == 0)) ||
                                     (t != (x == 0 && y == 0))));
      if (detect) m_err = 1'b1;
      else if (want_clr) m_err = 1'b0;
      m_primed = 1'b1;
      m_prev   = idx;
      e.de  = (x < HV) && (y < VV);
      e.hs  = !(inr && x >= HV + HF && x < HV + HF + HS);
      e.vs  = !(inr && y >= VV + VF && y < VV + VF + VS);
      e.rgb = e.de ? colour(x, y) : 12'h000;
      e.fc  = m_fc;
      e.err = m_err;
      p1 = p0;
      p0 = e;
   endtask

   // Legal raster stream from (cx,cy), optionally with random mode churn
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         if (rnd) begin
            if ($urandom_range(0, 299) == 0) begin
               want_psel = 2'($urandom_range(0, 3));
               want_scol = 12'($urandom);
            end
            want_clr = ($urandom_range(0, 149) == 0);
         end
         step(cx, cy, cx == 0, cx == 0 && cy == 0);
         cx++;
         if (cx == HT) begin
            cx = 0;
            cy = (cy + 1) % VT;
         end
      end
   endtask

   task automatic run_until(input int tx, input int ty);
      for (int i = 0; i < HT * VT && !(cx == tx && cy == ty); i++)
         run(1);
   endtask

   // Assert reset, check reset values, release with the next sample
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_video", 32'({hsync, vsync, display_enable, red, green, blue}), 32'h6000);
      chk("rst_state", 32'({frame_count, sequence_error}), 32'h0);
      m_fc = '0; m_mode = '0; m_solid = '0; m_err = 1'b0; m_primed = 1'b0; m_prev = 0;
      p0 = reset_rec();
      p1 = reset_rec();
      rel_pending = 1'b1;
   endtask

   initial begin
      reset = 1'b0; beam = '0; b2l = 1'b0; b2t = 1'b0;
      pattern_select = '0; solid_color = '0; error_clear = 1'b0;

      // x, y, top, psel, scol -> hs, vs, de, rgb
      tbl = '{
         '{0,   0,  1'b1, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFFF},
         '{15,  0,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFFF},
         '{16,  0,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFF0},
         '{47,  5,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h0FF},
         '{48,  5,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h0F0},
         '{64,  5,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hF0F},
         '{80,  5,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hF00},
         '{96,  5,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h00F},
         '{127, 39, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000},
         '{128, 39, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{135, 0,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{136, 0,  1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000},
         '{151, 0,  1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000},
         '{152, 0,  1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{0,   41, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{0,   42, 1'b0, 2'd0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000},
         '{143, 43, 1'b0, 2'd0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000},
         '{0,   44, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{140, 50, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{200, 42, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000},
         '{0,   0,  1'b1, 2'd1, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000},
         '{32,  0,  1'b0, 2'd1, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFFF},
         '{32,  32, 1'b0, 2'd1, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000},
         '{0,   33, 1'b0, 2'd1, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFFF},
         '{0,   0,  1'b1, 2'd3, 12'h5A3, 1'b1, 1'b1, 1'b1, 12'h5A3},
         '{100, 20, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h5A3},
         '{0,   0,  1'b1, 2'd2, 12'h000, 1'b1, 1'b1, 1'b1, 12'h004},
         '{127, 39, 1'b0, 2'd1, 12'h000, 1'b1, 1'b1, 1'b1, 12'h114}
      };

      // Isolated boundary pixels through the 2-cycle pipeline
      do_reset();
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (rel_pending) begin
            reset = 1'b1;
            rel_pending = 1'b0;
         end
         if (i >= 2)
            chk($sformatf("vec%0d", i - 2),
                32'({hsync, vsync, display_enable, red, green, blue}),
                32'({tbl[i-2].hs, tbl[i-2].vs, tbl[i-2].de, tbl[i-2].rgb}));
         if (i < 28) begin
            beam = {11'(tbl[i].y), 11'(tbl[i].x)};
            b2l = (tbl[i].x == 0);
            b2t = tbl[i].top;
            pattern_select = tbl[i].psel;
            solid_color = tbl[i].scol;
         end
      end
      chk("vec_fc", 32'(frame_count), 32'd4);

      // Bars, mid-frame switch to solid taking effect at the next frame
      do_reset();
      want_psel = 2'd0; want_scol = '0; cx = 0; cy = 0;
      run_until(0, 20);
      want_psel = 2'd3; want_scol = 12'h5A3;
      run_until(0, 0);
      run_until(5, 5);
      run(2);
      chk("solid_px", 32'({red, green, blue}), 32'h5A3);

      // Gradient over three frames
      do_reset();
      want_psel = 2'd2; cx = 0; cy = 0;
      run(HT * VT);
      run(3);
      chk("f2_blue", 32'(blue), 32'd2);
      run_until(0, 0);
      run(2);
      chk("fc3", 32'(frame_count), 32'd3);

      // Rest of frame 3 with random mode churn and clears
      rnd = 1'b1;
      run_until(0, 0);
      rnd = 1'b0;
      want_clr = 1'b0;

      // Skipped column, clear, then a dropped left pulse
      run_until(100, 1);
      run(1);
      cx = 102;
      run(3);
      chk("skip_err", 32'(sequence_error), 32'd1);
      want_clr = 1'b1;
      run(1);
      want_clr = 1'b0;
      run(2);
      chk("clear_err", 32'(sequence_error), 32'd0);
      run_until(0, 2);
      step(0, 2, 1'b0, 1'b0);
      cx = 1;
      run(2);
      chk("b2l_err", 32'(sequence_error), 32'd1);

      // Mid-frame reset, resume elsewhere without a fault
      run_until(60, 20);
      do_reset();
      cx = 100; cy = 30;
      run(1000);
      chk("post_rst_err", 32'(sequence_error), 32'd0);
      chk("post_rst_fc", 32'(frame_count), 32'd0);

      // Off-raster sample
      step(200, 10, 1'b0, 1'b0);
      step(201, 10, 1'b0, 1'b0);
      step(202, 10, 1'b0, 1'b0);
      chk("oor_err", 32'(sequence_error), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
